// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding and reset constants for the PC sequencer
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  // Wide all-ones constant; each user keeps the low N bits so the first increment lands on 0.
  localparam logic [31:0] RESET_PC = '1;

  function automatic logic is_fetching(input state_e s);
    return (s == ST_FETCH) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch, redirect and status signals of the PC sequencer
interface pc_sequencer_if #(
  parameter int N     = 9,
  parameter int CNT_W = 16
);
  logic             imem_req;
  logic [N-1:0]     imem_addr;
  logic             imem_ready;
  logic             instr_valid;
  logic             stall;
  logic             jmp;
  logic [N-1:0]     jmp_target;
  logic             br_taken;
  logic [N-1:0]     br_target;
  logic             halt;
  logic             resume;
  logic [N-1:0]     pc_cur;
  logic             pc_we;
  logic             halted;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output imem_req, imem_addr, instr_valid, pc_cur, pc_we, halted, retire_cnt,
    input  imem_ready, stall, jmp, jmp_target, br_taken, br_target, halt, resume
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, pc_cur, pc_we, halted, retire_cnt,
    output imem_ready, stall, jmp, jmp_target, br_taken, br_target, halt, resume
  );
endinterface

// File: rtl/pc_sequencer_next_pc_sel.sv
// rtl/pc_sequencer_next_pc_sel.sv - next-PC priority select: jump, then branch, then sequential
module next_pc_sel #(
  parameter int N = 9
) (
  input  logic [N-1:0] pc_cur,
  input  logic         jmp,
  input  logic [N-1:0] jmp_target,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  output logic [N-1:0] next_pc
);

  always_comb begin
    next_pc = pc_cur + 1'b1;
    if (jmp) begin
      next_pc = jmp_target;
    end else if (br_taken) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute program-counter sequencer with halt and retire counting
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int N     = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [N-1:0]     imem_addr,
  input  logic             imem_ready,
  output logic             instr_valid,
  input  logic             stall,
  input  logic             jmp,
  input  logic [N-1:0]     jmp_target,
  input  logic             br_taken,
  input  logic [N-1:0]     br_target,
  input  logic             halt,
  input  logic             resume,
  output logic [N-1:0]     pc_cur,
  output logic             pc_we,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt
);

  state_e           state_q, state_d;
  logic [N-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_upd;
  logic [N-1:0]     next_pc;
  logic             req_q, valid_q, we_q, halted_q;

  next_pc_sel #(.N(N)) u_next_pc_sel (
    .pc_cur     (pc_q),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .next_pc    (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    pc_upd  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pc_d    = pc_q + 1'b1;
        pc_upd  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: state_d = imem_ready ? ST_EXEC : ST_WAIT;
      ST_WAIT:  if (imem_ready) state_d = ST_EXEC;
      ST_EXEC: begin
        if (!stall) begin
          pc_d    = next_pc;
          pc_upd  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = halt ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT:  if (resume) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are flops loaded from the next state so they never glitch on state decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC[N-1:0];
      cnt_q    <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      req_q    <= is_fetching(state_d);
      valid_q  <= (state_d == ST_EXEC);
      we_q     <= pc_upd;
      halted_q <= (state_d == ST_HALT);
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign pc_cur      = pc_q;
  assign pc_we       = we_q;
  assign halted      = halted_q;
  assign retire_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   exp_ret  = 0;

  pc_sequencer_if #(.N(9), .CNT_W(16)) bus ();

  logic       w_req, w_valid, w_we, w_halted;
  logic [8:0] w_addr, w_pc;
  logic [3:0] w_cnt;

  always #5 clk = ~clk;

  pc_sequencer #(.N(9), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (bus.imem_req),
    .imem_addr   (bus.imem_addr),
    .imem_ready  (bus.imem_ready),
    .instr_valid (bus.instr_valid),
    .stall       (bus.stall),
    .jmp         (bus.jmp),
    .jmp_target  (bus.jmp_target),
    .br_taken    (bus.br_taken),
    .br_target   (bus.br_target),
    .halt        (bus.halt),
    .resume      (bus.resume),
    .pc_cur      (bus.pc_cur),
    .pc_we       (bus.pc_we),
    .halted      (bus.halted),
    .retire_cnt  (bus.retire_cnt)
  );

  // Narrow-counter copy driven by the same stimulus, used to reach counter wrap quickly.
  pc_sequencer #(.N(9), .CNT_W(4)) u_wrap (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_ready  (bus.imem_ready),
    .instr_valid (w_valid),
    .stall       (bus.stall),
    .jmp         (bus.jmp),
    .jmp_target  (bus.jmp_target),
    .br_taken    (bus.br_taken),
    .br_target   (bus.br_target),
    .halt        (bus.halt),
    .resume      (bus.resume),
    .pc_cur      (w_pc),
    .pc_we       (w_we),
    .halted      (w_halted),
    .retire_cnt  (w_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    bus.imem_ready = 1'b1;
    bus.stall      = 1'b0;
    bus.jmp        = 1'b0;
    bus.jmp_target = '0;
    bus.br_taken   = 1'b0;
    bus.br_target  = '0;
    bus.halt       = 1'b0;
    bus.resume     = 1'b0;
    tick();
    tick();
    check("rst_req",    bus.imem_req,    0);
    check("rst_valid",  bus.instr_valid, 0);
    check("rst_we",     bus.pc_we,       0);
    check("rst_halted", bus.halted,      0);
    check("rst_pc",     bus.pc_cur,      9'h1FF);
    check("rst_cnt",    bus.retire_cnt,  0);

    rst = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("seq_req",  bus.imem_req,   1);
      check("seq_addr", bus.imem_addr,  i);
      check("seq_we",   bus.pc_we,      1);
      check("seq_cnt",  bus.retire_cnt, exp_ret);
      tick();
      check("seq_valid",  bus.instr_valid, 1);
      check("seq_noreq",  bus.imem_req,    0);
      check("seq_exec_we", bus.pc_we,      0);
      tick();
      exp_ret++;
    end

    bus.imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.imem_ready = 1'b1;
      check("wait_req",  bus.imem_req,  1);
      check("wait_addr", bus.imem_addr, 9'h005);
      if (i > 0) check("wait_no_we", bus.pc_we, 0);
      tick();
    end
    check("wait_exec", bus.instr_valid, 1);

    bus.jmp = 1'b1;
    bus.jmp_target = 9'h010;
    tick();
    exp_ret++;
    bus.jmp = 1'b0;
    check("jmp10_addr", bus.imem_addr, 9'h010);
    tick();
    bus.stall = 1'b1;
    bus.jmp = 1'b1;
    bus.jmp_target = 9'h0A0;
    bus.br_taken = 1'b1;
    bus.br_target = 9'h123;
    tick();
    check("stall1_pc",    bus.pc_cur,      9'h010);
    check("stall1_we",    bus.pc_we,       0);
    check("stall1_valid", bus.instr_valid, 1);
    tick();
    check("stall2_pc", bus.pc_cur, 9'h010);
    check("stall2_we", bus.pc_we,  0);
    bus.stall = 1'b0;
    tick();
    exp_ret++;
    bus.jmp = 1'b0;
    bus.br_taken = 1'b0;
    check("prio_addr", bus.imem_addr, 9'h0A0);
    check("prio_we",   bus.pc_we,     1);
    check("prio_cnt",  bus.retire_cnt, exp_ret);

    tick();
    bus.jmp = 1'b1;
    bus.jmp_target = 9'h1FF;
    tick();
    exp_ret++;
    bus.jmp = 1'b0;
    check("top_addr", bus.imem_addr, 9'h1FF);
    tick();
    tick();
    exp_ret++;
    check("wrap_addr", bus.imem_addr, 9'h000);
    check("wrap_req",  bus.imem_req,  1);

    while (exp_ret < 16) begin
      tick();
      tick();
      exp_ret++;
      if (exp_ret == 15) check("cnt4_max", w_cnt, 15);
    end
    check("cnt4_wrap", w_cnt, 0);
    check("cnt16_val", bus.retire_cnt, 16);

    tick();
    bus.halt = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_target = 9'h040;
    tick();
    exp_ret++;
    bus.halt = 1'b0;
    bus.br_taken = 1'b0;
    check("halt_halted", bus.halted, 1);
    check("halt_pc",     bus.pc_cur, 9'h040);
    check("halt_we",     bus.pc_we,  1);
    check("halt_cnt",    bus.retire_cnt, exp_ret);
    for (int i = 0; i < 10; i++) begin
      check("halt_noreq", bus.imem_req, 0);
      tick();
    end
    check("halt_hold", bus.halted, 1);
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    check("resume_req",    bus.imem_req,  1);
    check("resume_addr",   bus.imem_addr, 9'h040);
    check("resume_halted", bus.halted,    0);

    bus.imem_ready = 1'b0;
    tick();
    check("rw_wait_req", bus.imem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("rw_req_drop", bus.imem_req,   0);
    check("rw_cnt",      bus.retire_cnt, 0);
    check("rw_pc",       bus.pc_cur,     9'h1FF);
    check("rw_we",       bus.pc_we,      0);
    tick();
    rst = 1'b1;
    bus.imem_ready = 1'b1;
    tick();
    check("rw_first_req",  bus.imem_req,  1);
    check("rw_first_addr", bus.imem_addr, 9'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter N, default 9, giving the program-counter width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, giving the retired-instruction counter width.
REQ-003 SHALL have ports in this order, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- imem_req  out  1  instruction-fetch request.
- imem_addr  out  N  fetch address.
- imem_ready  in  1  memory accepts the request and returns an instruction.
- instr_valid  out  1  the fetched instruction is being executed.
- stall  in  1  execute stage not finished; hold the PC.
- jmp  in  1  unconditional jump request.
- jmp_target  in  N  jump destination.
- br_taken  in  1  branch resolved taken.
- br_target  in  N  branch destination.
- halt  in  1  halt request.
- resume  in  1  leave HALT.
- pc_cur  out  N  current PC register.
- pc_we  out  1  one-cycle pulse when pc_cur is updated.
- halted  out  1  high while in HALT.
- retire_cnt  out  CNT_W  count of retired instructions.

Function
REQ-004 SHALL implement the FSM states IDLE, FETCH, WAIT, EXEC and HALT.
REQ-005 IDLE (first cycle after reset release): set pc_cur <= pc_cur+1 (all-ones wraps to 0), pulse pc_we, go to FETCH.
REQ-006 FETCH: imem_req=1 and imem_addr=pc_cur; if imem_ready=1 go to EXEC, else go to WAIT.
REQ-007 WAIT: hold imem_req=1 with imem_addr stable; go to EXEC on the first cycle with imem_ready=1.
REQ-008 EXEC: instr_valid=1 and imem_req=0; while stall=1 stay in EXEC with pc_cur unchanged.
REQ-009 On EXEC with stall=0, the next PC SHALL be, in priority order:
- jmp_target when jmp=1;
- br_target when br_taken=1;
- otherwise pc_cur+1, modulo 2^N.
REQ-010 On that EXEC exit cycle the block SHALL load pc_cur, pulse pc_we, and increment retire_cnt modulo 2^CNT_W.
REQ-011 EXEC exit SHALL go to HALT if halt=1, else to FETCH; when halt and jmp/br_taken are high together, the redirect is committed first, then HALT.
REQ-012 HALT: halted=1 and no request is issued; resume=1 goes to FETCH at the already-updated pc_cur.
REQ-013 halt SHALL be ignored outside EXEC, resume outside HALT, imem_ready outside FETCH/WAIT, and jmp/br_taken outside EXEC or while stall=1.
REQ-014 Throughput with a zero-wait memory and no stall SHALL be one instruction per 2 cycles; each wait cycle adds 1 cycle.
REQ-015 imem_addr SHALL equal pc_cur in all states; imem_req SHALL be driven directly from the state register, glitch-free.

Reset
REQ-016 While rst=0, asynchronously:
- state=IDLE;
- pc_cur={N{1'b1}};
- imem_req=0, instr_valid=0, pc_we=0, halted=0;
- retire_cnt=0.
REQ-017 Reset asserted mid-WAIT or mid-EXEC SHALL drop imem_req and instr_valid immediately and discard the pending instruction, with no retire and no pc_we.
REQ-018 The first fetch after any reset SHALL be at address 0.

Structure
REQ-019 The shared package SHALL hold the state encoding (3-bit enum) and the localparam RESET_PC = all-ones.
REQ-020 The next-PC priority select SHALL be a combinational sub-module, next_pc_sel (inputs pc_cur, jmp, jmp_target, br_taken, br_target; output next_pc); the FSM, PC register and counter stay in pc_sequencer.

Verification
REQ-021 Reset then zero-wait memory, no stall -> fetches at 0,1,2,3 on every other cycle; pc_we pulses; retire_cnt=3 after the third EXEC.
REQ-022 imem_ready held low 3 cycles at address 5 -> imem_req and imem_addr=5 stable for 4 cycles, then EXEC; no pc_we during WAIT.
REQ-023 In EXEC at pc 0x010 with jmp=1 (0x0A0) and br_taken=1 (0x123) -> next fetch at 0x0A0; stall=1 for 2 cycles delays the update by exactly 2 cycles.
REQ-024 pc_cur=0x1FF with no redirect (N=9) -> next fetch at 0x000; retire_cnt=0xFFFF rolls to 0x0000.
REQ-025 halt=1 with br_taken=1 (0x040) -> halted=1, pc_cur=0x040, no imem_req for 10 cycles; resume=1 -> fetch at 0x040.
REQ-026 rst pulsed low during WAIT -> imem_req drops in the same cycle and retire_cnt=0; after release the first fetch is at 0.
